// File: rtl/rsp_router_pkg.sv
// Chip-wide constants and types shared by the arbiter and response router.
package rsp_router_pkg;

  localparam int NUM_OF_CORES    = 4;
  localparam int DATA_WIDTH      = 64;
  localparam int MAX_OUTSTANDING = 8;

  localparam int CORE_IDX_W = (NUM_OF_CORES > 1) ? $clog2(NUM_OF_CORES) : 1;

  typedef logic [CORE_IDX_W-1:0] core_idx_t;

endpackage

// File: rtl/rsp_router_onehot_to_idx.sv
// Combinational one-hot encoder: grant vector to core index plus a validity flag.
module onehot_to_idx
  import rsp_router_pkg::*;
(
  input  logic [NUM_OF_CORES-1:0] onehot,
  output core_idx_t               idx,
  output logic                    onehot_ok
);

  // Encode the highest set bit; onehot_ok tells the caller whether the index means anything.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    idx       = '0;
    onehot_ok = 1'b0;
    for (int i = 0; i < NUM_OF_CORES; i++) begin
      if (onehot[i]) begin
        idx = core_idx_t'(i);
      end
    end
    onehot_ok = (onehot != '0) && ((onehot & (onehot - NUM_OF_CORES'(1))) == '0);
  end

endmodule

// File: rtl/rsp_router.sv
// Response router: remembers which core owns each accepted memory request and
// steers the in-order memory responses back to that core.
module rsp_router
  import rsp_router_pkg::*;
#(
  parameter int MAX_OUTSTANDING_P = MAX_OUTSTANDING,
  localparam int PTR_W = $clog2(MAX_OUTSTANDING_P) + 1,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING_P + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_OF_CORES-1:0] req_grant,
  input  logic                    req_fire,
  output logic                    req_stall,
  input  logic                    mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rsp_data,
  output logic                    mem_rsp_ready,
  output logic [NUM_OF_CORES-1:0] core_rsp_valid,
  output logic [DATA_WIDTH-1:0]   core_rsp_data,
  input  logic [NUM_OF_CORES-1:0] core_rsp_ready,
  output logic [CNT_W-1:0]        outstanding,
  output logic                    grant_err,
  output logic                    orphan_err
);

  localparam int AW = PTR_W - 1;

  // Tag FIFO: one extra pointer bit distinguishes full from empty.
  core_idx_t       fifo_mem [MAX_OUTSTANDING_P];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] fifo_count;
  logic             fifo_empty;
  logic             fifo_full;

  // Output register presented to the cores.
  logic                  out_valid;
  core_idx_t             out_idx;
  logic [DATA_WIDTH-1:0] out_data;

  core_idx_t grant_idx;
  logic      grant_ok;
  logic      push;
  logic      grant_bad;
  logic      out_ready;
  logic      accept;
  logic      retire;
  logic      orphan;

  onehot_to_idx u_enc (
    .onehot    (req_grant),
    .idx       (grant_idx),
    .onehot_ok (grant_ok)
  );

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign fifo_count = wr_ptr - rd_ptr;

  // Stall depends on the registered pointers only, so a same-cycle pop cannot lower it.
  assign req_stall = fifo_full;

  // A fire while stalled is dropped silently; a bad grant is only flagged when it could push.
  assign push      = req_fire && !fifo_full && grant_ok;
  assign grant_bad = req_fire && !fifo_full && !grant_ok;

  assign out_ready     = core_rsp_ready[out_idx];
  assign mem_rsp_ready = !fifo_empty && (!out_valid || out_ready);
  assign accept        = mem_rsp_valid && mem_rsp_ready;
  assign retire        = out_valid && out_ready && !accept;
  assign orphan        = mem_rsp_valid && fifo_empty && !out_valid;

  assign core_rsp_valid = out_valid ? (NUM_OF_CORES'(1) << out_idx) : '0;
  assign core_rsp_data  = out_data;
  assign outstanding    = CNT_W'(fifo_count) + CNT_W'(out_valid);

  // Tag storage writes at the tail; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    // NOTE: the array is left unreset; pointers alone decide which entries are live.
    if (!reset && push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= grant_idx;
    end
  end

  // Pointers, output register and sticky error flags.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_data   <= '0;
      grant_err  <= 1'b0;
      orphan_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (accept) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        out_idx   <= fifo_mem[rd_ptr[AW-1:0]];
        out_data  <= mem_rsp_data;
        out_valid <= 1'b1;
      end else if (retire) begin
        out_valid <= 1'b0;
      end
      if (grant_bad) begin
        grant_err <= 1'b1;
      end
      if (orphan) begin
        orphan_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rsp_router.sv
// Directed bench for rsp_router with a scoreboard queue checked by a monitor.
module tb_rsp_router;
  import rsp_router_pkg::*;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_OF_CORES-1:0] req_grant;
  logic                    req_fire;
  logic                    req_stall;
  logic                    mem_rsp_valid;
  logic [DATA_WIDTH-1:0]   mem_rsp_data;
  logic                    mem_rsp_ready;
  logic [NUM_OF_CORES-1:0] core_rsp_valid;
  logic [DATA_WIDTH-1:0]   core_rsp_data;
  logic [NUM_OF_CORES-1:0] core_rsp_ready;
  logic [3:0]              outstanding;
  logic                    grant_err;
  logic                    orphan_err;

  typedef struct {
    core_idx_t             idx;
    logic [DATA_WIDTH-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  rsp_router dut (
    .clk            (clk),
    .reset          (reset),
    .req_grant      (req_grant),
    .req_fire       (req_fire),
    .req_stall      (req_stall),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_ready  (mem_rsp_ready),
    .core_rsp_valid (core_rsp_valid),
    .core_rsp_data  (core_rsp_data),
    .core_rsp_ready (core_rsp_ready),
    .outstanding    (outstanding),
    .grant_err      (grant_err),
    .orphan_err     (orphan_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rsp(input core_idx_t idx, input logic [DATA_WIDTH-1:0] data);
    exp_t e;
    e.idx  = idx;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_stall"},      64'(req_stall),      64'd0);
    check({tag, "_mem_rsp_ready"},  64'(mem_rsp_ready),  64'd0);
    check({tag, "_core_rsp_valid"}, 64'(core_rsp_valid), 64'd0);
    check({tag, "_core_rsp_data"},  64'(core_rsp_data),  64'd0);
    check({tag, "_outstanding"},    64'(outstanding),    64'd0);
    check({tag, "_grant_err"},      64'(grant_err),      64'd0);
    check({tag, "_orphan_err"},     64'(orphan_err),     64'd0);
  endtask

  // Monitor: every completed core handshake must match the oldest expected response.
  initial begin
    exp_t                    e;
    logic [NUM_OF_CORES-1:0] exp_v;
    forever begin
      @(negedge clk);
      if (!reset && ((core_rsp_valid & core_rsp_ready) != '0)) begin
        if (sb.size() == 0) begin
          check("unexpected_delivery", 64'(core_rsp_valid), 64'd0);
        end else begin
          e     = sb.pop_front();
          exp_v = NUM_OF_CORES'(1) << e.idx;
          check("rsp_valid", 64'(core_rsp_valid), 64'(exp_v));
          check("rsp_data",  core_rsp_data,       e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [NUM_OF_CORES-1:0] order [4];
    core_idx_t               order_idx [4];
    order[0] = 4'b0001; order_idx[0] = 2'd0;
    order[1] = 4'b1000; order_idx[1] = 2'd3;
    order[2] = 4'b0010; order_idx[2] = 2'd1;
    order[3] = 4'b0100; order_idx[3] = 2'd2;

    reset          = 1'b1;
    req_grant      = '0;
    req_fire       = 1'b0;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = '0;
    core_rsp_ready = '0;
    repeat (2) step();
    @(negedge clk);
    check_reset_values("rst");
    step();
    reset          = 1'b0;
    core_rsp_ready = 4'b1111;

    // Single response to core 2.
    req_grant = 4'b0100;
    req_fire  = 1'b1;
    step();
    req_fire      = 1'b0;
    req_grant     = '0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'hA5;
    expect_rsp(2'd2, 64'hA5);
    @(negedge clk);
    check("single_mem_ready", 64'(mem_rsp_ready), 64'd1);
    check("single_outst_1",   64'(outstanding),   64'd1);
    step();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    check("single_outst_held", 64'(outstanding), 64'd1);
    step();
    @(negedge clk);
    check("single_outst_0", 64'(outstanding), 64'd0);

    // Ordering: cores 0,3,1,2 then four back-to-back responses.
    step();
    for (int i = 0; i < 4; i++) begin
      req_grant = order[i];
      req_fire  = 1'b1;
      step();
    end
    req_fire  = 1'b0;
    req_grant = '0;
    for (int i = 0; i < 4; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 64'hD0 + 64'(i);
      expect_rsp(order_idx[i], 64'hD0 + 64'(i));
      @(negedge clk);
      check("order_mem_ready", 64'(mem_rsp_ready), 64'd1);
      step();
    end
    mem_rsp_valid = 1'b0;
    repeat (2) step();
    @(negedge clk);
    check("order_outst_0", 64'(outstanding), 64'd0);

    // Full: eight tags, then an extra fire that must be ignored.
    step();
    for (int i = 0; i < 8; i++) begin
      req_grant = 4'b0001 << (i % 4);
      req_fire  = 1'b1;
      step();
    end
    req_fire = 1'b0;
    @(negedge clk);
    check("full_stall",   64'(req_stall),   64'd1);
    check("full_outst_8", 64'(outstanding), 64'd8);
    step();
    req_grant = 4'b0001;
    req_fire  = 1'b1;
    step();
    req_fire  = 1'b0;
    req_grant = '0;
    @(negedge clk);
    check("full_extra_fire_outst", 64'(outstanding), 64'd8);
    check("full_extra_fire_gerr",  64'(grant_err),   64'd0);
    step();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'hF0;
    expect_rsp(2'd0, 64'hF0);
    @(negedge clk);
    check("full_stall_during_pop", 64'(req_stall),     64'd1);
    check("full_pop_ready",        64'(mem_rsp_ready), 64'd1);
    step();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    check("full_stall_dropped", 64'(req_stall), 64'd0);
    step();
    for (int i = 1; i < 8; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 64'hF0 + 64'(i);
      expect_rsp(core_idx_t'(i % 4), 64'hF0 + 64'(i));
      step();
    end
    mem_rsp_valid = 1'b0;
    repeat (2) step();
    @(negedge clk);
    check("full_drained", 64'(outstanding), 64'd0);

    // Backpressure on core 1 with a second response waiting for core 0.
    step();
    core_rsp_ready = 4'b1101;
    req_grant      = 4'b0010;
    req_fire       = 1'b1;
    step();
    req_grant = 4'b0001;
    step();
    req_fire      = 1'b0;
    req_grant     = '0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'hB0;
    expect_rsp(2'd1, 64'hB0);
    step();
    mem_rsp_data = 64'hB1;
    expect_rsp(2'd0, 64'hB1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid_held", 64'(core_rsp_valid), 64'(4'b0010));
      check("bp_data_held",  core_rsp_data,       64'hB0);
      check("bp_mem_ready",  64'(mem_rsp_ready),  64'd0);
      step();
    end
    core_rsp_ready = 4'b1111;
    @(negedge clk);
    check("bp_release_accept", 64'(mem_rsp_ready), 64'd1);
    step();
    mem_rsp_valid = 1'b0;
    repeat (2) step();
    @(negedge clk);
    check("bp_outst_0", 64'(outstanding), 64'd0);

    // Error flags.
    step();
    req_grant = 4'b0110;
    req_fire  = 1'b1;
    step();
    req_fire  = 1'b0;
    req_grant = '0;
    @(negedge clk);
    check("grant_err_set",   64'(grant_err),   64'd1);
    check("grant_err_outst", 64'(outstanding), 64'd0);
    step();
    mem_rsp_valid = 1'b1;
    @(negedge clk);
    check("orphan_mem_ready", 64'(mem_rsp_ready), 64'd0);
    step();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    check("orphan_err_set", 64'(orphan_err), 64'd1);

    // Reset with three outstanding (two tags plus a held response for core 2).
    step();
    core_rsp_ready = '0;
    req_grant      = 4'b0100;
    req_fire       = 1'b1;
    repeat (3) step();
    req_fire      = 1'b0;
    req_grant     = '0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 64'hC0;
    step();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    check("mid_outst_3",   64'(outstanding),    64'd3);
    check("mid_held_core", 64'(core_rsp_valid), 64'(4'b0100));
    step();
    reset = 1'b1;
    step();
    @(negedge clk);
    check_reset_values("midrst");
    step();
    reset          = 1'b0;
    core_rsp_ready = 4'b1111;
    @(negedge clk);
    check("post_rst_mem_ready", 64'(mem_rsp_ready), 64'd0);
    check("post_rst_outst",     64'(outstanding),   64'd0);

    repeat (2) step();
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rsp_router.md
# rsp_router

Response-side companion to the core arbiter. It records the order in which granted core requests are accepted by the shared memory port. It then steers each in-order memory response back to the core that issued it, using a per-core valid/ready handshake. It sits between the memory response channel and the per-core response inputs, and it throttles the arbiter when its tag store is full.

## Interface
- NUM_OF_CORES, 4, number of requesting cores (from shared package)
- MAX_OUTSTANDING, 8, tag FIFO depth (power of two, ≥2)
- DATA_WIDTH, 64, response payload width

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_grant  in  NUM_OF_CORES  one-hot grant from arbiter
- req_fire  in  1  granted request accepted by memory this cycle
- req_stall  out  1  tag FIFO full; arbiter must not fire
- mem_rsp_valid  in  1  memory response valid
- mem_rsp_data  in  DATA_WIDTH  memory response payload
- mem_rsp_ready  out  1  response accepted this cycle
- core_rsp_valid  out  NUM_OF_CORES  one-hot response valid to cores
- core_rsp_data  out  DATA_WIDTH  payload broadcast to all cores
- core_rsp_ready  in  NUM_OF_CORES  per-core accept
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  FIFO entries plus held output
- grant_err  out  1  sticky: req_fire with non-one-hot req_grant
- orphan_err  out  1  sticky: mem_rsp_valid while FIFO empty and output idle

## Operation
- **Push.** On req_fire && !req_stall && req_grant one-hot, encode req_grant to an index and write it to the FIFO tail.
- **Bad grant.** A req_fire with a zero or multi-hot grant sets grant_err and pushes nothing.
- **Fire while stalled.** req_fire while req_stall is high is a protocol violation. It is ignored and not flagged.
- **Output register.** The output holds out_valid, out_idx and out_data.
- **Response accept.** mem_rsp_ready = fifo_not_empty && (!out_valid || core_rsp_ready[out_idx]).
- **Accept action.** On mem_rsp_valid && mem_rsp_ready:
  - pop the FIFO head into out_idx;
  - load mem_rsp_data into out_data;
  - set out_valid.
- **Delivery.** core_rsp_valid = out_valid ? (1 << out_idx) : 0. core_rsp_data = out_data.
- **Retire.** When core_rsp_ready[out_idx] is high and no new accept occurs in the same cycle, clear out_valid.
- **Orphan response.** When mem_rsp_valid is high, the FIFO is empty and out_valid is low, set orphan_err. mem_rsp_ready stays low.
- **outstanding.** Equals FIFO count + out_valid. It increments on push and decrements on retire; push and retire together leave it unchanged.
- **Error flags.** Both error flags clear only on reset.

## Timing
- **Reset values.** req_stall=0, mem_rsp_ready=0, core_rsp_valid=0, core_rsp_data=0, outstanding=0, grant_err=0, orphan_err=0. FIFO pointers are zero.
- **req_stall.** Comes combinationally from FIFO full only. A pop in the same cycle does not lower it.
- **Push to accept.** An entry pushed in cycle N can enable mem_rsp_ready from cycle N+1. A response in the same cycle as the first push is not accepted.
- **Accept to delivery.** A response accepted in cycle N appears on core_rsp_valid/core_rsp_data in cycle N+1 (latency 1).
- **Back-to-back.** If the target core's ready is held high, one response per cycle is delivered.
- **Held output.** While core_rsp_ready[out_idx] is low, out_* holds stable and mem_rsp_ready is low.
- **Pointer wrap.** Pointers are log2(MAX_OUTSTANDING)+1 bits. Full when the MSBs differ and the low bits are equal; empty when the pointers are equal.
- **Reset mid-operation.** All pending tags and the held response are discarded.

## Structure
- **Shared package.** NUM_OF_CORES, the core-index typedef core_idx_t ($clog2(NUM_OF_CORES) bits) and DATA_WIDTH live in the chip-wide package.
- **Sub-module.** onehot_to_idx: combinational encoder. Outputs the index plus an onehot_ok flag (exactly one bit set).
- **FIFO.** Kept inline as a register array with read/write pointers. No separate FIFO module.

## Test plan
- **Single response.** After reset: req_grant=4'b0100 with req_fire, then mem_rsp_valid with data 0xA5 one cycle later → next cycle core_rsp_valid=4'b0100, data 0xA5, outstanding returns to 0 after ready.
- **Ordering.** Fire grants to cores 0,3,1,2, then four responses D0..D3 with all readies high → delivered to cores 0,3,1,2 in order, one per cycle.
- **Full.** Push 8 tags with no responses → req_stall=1, outstanding=8. A further req_fire is not counted. One accept → req_stall drops the following cycle.
- **Backpressure.** core_rsp_ready[1]=0 for 5 cycles with a response held for core 1 → output stable, mem_rsp_ready=0. Ready asserted → delivered and the next response accepted the same cycle.
- **Errors.** req_fire with req_grant=4'b0110 → grant_err=1, outstanding unchanged. mem_rsp_valid with outstanding=0 → orphan_err=1, mem_rsp_ready=0.
- **Reset mid-run.** Apply reset with 3 outstanding and a response held → all outputs return to their reset values next cycle.
